// File: rtl/countdown_pkg.sv
// Shared types and default sizes for the countdown timer.
package countdown_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_PRE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Host-side control and status bundle for the countdown timer.
interface countdown_timer_if
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned PRE_W = DEF_PRE_W
) ();

    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic [PRE_W-1:0] prescale;
    logic             enable;
    logic [WIDTH-1:0] count;
    logic             tc_pulse;
    logic             done;
    logic             busy;

    modport master (
        output clear, load, load_value, auto_reload, prescale, enable,
        input  count, tc_pulse, done, busy
    );

    modport slave (
        input  clear, load, load_value, auto_reload, prescale, enable,
        output count, tc_pulse, done, busy
    );

endinterface

// File: rtl/countdown_prescaler.sv
// Divides enabled cycles by div+1; tick marks the last cycle of each period.
module countdown_prescaler
    import countdown_pkg::*;
#(
    parameter int unsigned PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             enable,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    // Tick on the enabled cycle where the counter has reached the divider.
    assign tick = enable && (cnt_q == div);

    // Next counter value: restart and wrap both return to zero; pause holds.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + PRE_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, one-shot/auto-reload modes and terminal-count flags.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned PRE_W = DEF_PRE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    countdown_timer_if.slave    bus
);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             auto_q,   auto_d;
    logic [PRE_W-1:0] div_q,    div_d;
    logic             tc_q,     tc_d;
    logic             done_q,   done_d;
    logic             busy_q,   busy_d;

    logic             restart_c;
    logic             run_en_c;
    logic             tick;

    // The prescaler restarts on any load or clear and only advances while running.
    assign restart_c = bus.clear || bus.load;
    assign run_en_c  = (state_q == RUN) && bus.enable;

    countdown_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart_c),
        .enable  (run_en_c),
        .div     (div_q),
        .tick    (tick)
    );

    // Next-state and next-output logic; clear beats load beats counting.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        auto_d   = auto_q;
        div_d    = div_q;
        tc_d     = 1'b0;
        done_d   = done_q;

        if (bus.clear) begin
            state_d = IDLE;
            count_d = '0;
            done_d  = 1'b0;
        end else if (bus.load) begin
            reload_d = bus.load_value;
            auto_d   = bus.auto_reload;
            div_d    = bus.prescale;
            count_d  = bus.load_value;
            if (bus.load_value != '0) begin
                state_d = RUN;
                done_d  = 1'b0;
            end else begin
                // A zero load is an immediate terminal count.
                state_d = DONE;
                done_d  = 1'b1;
                tc_d    = 1'b1;
            end
        end else if ((state_q == RUN) && tick) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else if (auto_q) begin
                // Reload straight from 1 so the period is exactly N ticks.
                count_d = reload_q;
                tc_d    = 1'b1;
            end else begin
                count_d = '0;
                state_d = DONE;
                done_d  = 1'b1;
                tc_d    = 1'b1;
            end
        end

        busy_d = (state_d == RUN);
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            auto_q   <= 1'b0;
            div_q    <= '0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            auto_q   <= auto_d;
            div_q    <= div_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.tc_pulse = tc_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer (WIDTH=4, PRE_W=4).
module tb_countdown_timer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned PRE_W = 4;

    typedef struct {
        int               when;
        string            tag;
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             done;
        logic             busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    countdown_timer_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

    countdown_timer #(
        .WIDTH (WIDTH),
        .PRE_W (PRE_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: cyc equals the number of rising edges seen so far.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance one clock edge and settle past it before touching inputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect the given outputs after the edge just taken.
    task automatic expect_out(input string tag, input int c, input bit tc, input bit d, input bit b);
        exp_t e;
        e.when  = cyc;
        e.tag   = tag;
        e.count = WIDTH'(c);
        e.tc    = tc;
        e.done  = d;
        e.busy  = b;
        sb.push_back(e);
    endtask

    task automatic drive(input bit clr, input bit ld, input int lv, input bit ar, input int ps, input bit en);
        bus.clear       = clr;
        bus.load        = ld;
        bus.load_value  = WIDTH'(lv);
        bus.auto_reload = ar;
        bus.prescale    = PRE_W'(ps);
        bus.enable      = en;
    endtask

    // Monitor: compare the DUT outputs against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (sb[0].when == cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_tests++;
                if ({bus.count, bus.tc_pulse, bus.done, bus.busy} !== {e.count, e.tc, e.done, e.busy}) begin
                    n_fail++;
                    $display("FAIL %s @edge %0d: got count=%0d tc=%b done=%b busy=%b, want count=%0d tc=%b done=%b busy=%b",
                             e.tag, cyc, bus.count, bus.tc_pulse, bus.done, bus.busy,
                             e.count, e.tc, e.done, e.busy);
                end
            end else if (sb[0].when < cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL %s: expectation for edge %0d not sampled (now %0d)", e.tag, e.when, cyc);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(0, 0, 0, 0, 0, 1);

        // Reset state
        step(); expect_out("reset", 0, 0, 0, 0);
        step(); expect_out("reset_hold", 0, 0, 0, 0);
        rst_n = 1'b1;
        step(); expect_out("idle", 0, 0, 0, 0);

        // 1: one-shot N=15, prescale 0
        drive(0, 1, 15, 0, 0, 1);
        step(); expect_out("t1_load", 15, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 14; i >= 1; i--) begin
            step(); expect_out("t1_down", i, 0, 0, 1);
        end
        step(); expect_out("t1_tc", 0, 1, 1, 0);
        step(); expect_out("t1_done", 0, 0, 1, 0);
        step(); expect_out("t1_done_hold", 0, 0, 1, 0);

        // 2: auto-reload N=3
        drive(0, 1, 3, 1, 0, 1);
        step(); expect_out("t2_load", 3, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        for (int p = 0; p < 3; p++) begin
            step(); expect_out("t2_c2", 2, 0, 0, 1);
            step(); expect_out("t2_c1", 1, 0, 0, 1);
            step(); expect_out("t2_reload", 3, 1, 0, 1);
        end

        // 3: N=2, prescale=2, loaded over a running auto-reload count
        drive(0, 1, 2, 0, 2, 1);
        step(); expect_out("t3_load", 2, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        step(); expect_out("t3_hold2a", 2, 0, 0, 1);
        step(); expect_out("t3_hold2b", 2, 0, 0, 1);
        step(); expect_out("t3_c1", 1, 0, 0, 1);
        step(); expect_out("t3_hold1a", 1, 0, 0, 1);
        step(); expect_out("t3_hold1b", 1, 0, 0, 1);
        step(); expect_out("t3_tc", 0, 1, 1, 0);
        step(); expect_out("t3_done", 0, 0, 1, 0);

        // 4: pause at count 7
        drive(0, 1, 9, 0, 0, 1);
        step(); expect_out("t4_load", 9, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        step(); expect_out("t4_c8", 8, 0, 0, 1);
        step(); expect_out("t4_c7", 7, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(); expect_out("t4_pause", 7, 0, 0, 1);
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 6; i >= 1; i--) begin
            step(); expect_out("t4_resume", i, 0, 0, 1);
        end

        // 8: reload N=9 while a terminal tick is pending at count 1
        drive(0, 1, 9, 0, 0, 1);
        step(); expect_out("t8_reload", 9, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        step(); expect_out("t8_c8", 8, 0, 0, 1);

        // 6: clear and load together during RUN
        drive(1, 1, 5, 0, 0, 1);
        step(); expect_out("t6_clear", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        step(); expect_out("t6_idle", 0, 0, 0, 0);

        // 5: load N=0
        drive(0, 1, 0, 0, 0, 1);
        step(); expect_out("t5_zero_tc", 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        step(); expect_out("t5_done", 0, 0, 1, 0);
        step(); expect_out("t5_done_hold", 0, 0, 1, 0);

        // 7: reset at count 5
        drive(0, 1, 8, 0, 0, 1);
        step(); expect_out("t7_load", 8, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        step(); expect_out("t7_c7", 7, 0, 0, 1);
        step(); expect_out("t7_c6", 6, 0, 0, 1);
        step(); expect_out("t7_c5", 5, 0, 0, 1);
        rst_n = 1'b0;
        step(); expect_out("t7_reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        step(); expect_out("t7_after", 0, 0, 0, 0);
        step(); expect_out("t7_idle", 0, 0, 0, 0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            step();
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
